// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle multiply/divide sequencer for the EX stage.
// Owns the HI/LO registers, stalls the front of the pipeline while an
// operation is in flight and accepts MTHI/MTLO writes from WB.
module muldiv_ctrl (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        cancel,
   input  logic [1:0]  hilo_we,
   input  logic [31:0] hilo_wdata,
   output logic        md_stall,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX,
      S_DONE
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [4:0]         r_cnt;
   logic [1:0]         r_op;
   logic               r_signA;
   logic               r_signB;
   logic               r_divZero;
   logic [31:0]        r_a;
   logic [31:0]        r_b;
   logic [63:0]        r_acc;
   logic [31:0]        r_hi;
   logic [31:0]        r_lo;

   logic               w_signedDiv;
   logic [31:0]        w_absA;
   logic [31:0]        w_absB;
   logic [31:0]        w_opA;
   logic [31:0]        w_opB;
   logic signed [63:0] w_prodS;
   logic [63:0]        w_prodU;
   logic [64:0]        w_shift;
   logic [32:0]        w_trial;
   logic [31:0]        w_quoFix;
   logic [31:0]        w_remFix;

   // Signed DIV runs on magnitudes; signs are restored in FIX.
   assign w_signedDiv = (op == 2'b10);
   assign w_absA      = src_a[31] ? (~src_a + 32'd1) : src_a;
   assign w_absB      = src_b[31] ? (~src_b + 32'd1) : src_b;
   assign w_opA       = w_signedDiv ? w_absA : src_a;
   assign w_opB       = w_signedDiv ? w_absB : src_b;

   // Full 64-bit products; the signed one sign-extends both operands first.
   assign w_prodS = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
   assign w_prodU = {32'd0, r_a} * {32'd0, r_b};

   // One restoring-division step: shift {rem, quo} left and try a subtract.
   // A 33-bit window keeps the carry when the divisor has bit 31 set.
   assign w_shift = {r_acc, 1'b0};
   assign w_trial = w_shift[64:32] - {1'b0, r_b};

   // Sign correction: quotient negated on differing signs, remainder
   // follows the dividend; a zero divisor always yields an all-ones quotient.
   assign w_quoFix = r_divZero ? 32'hFFFF_FFFF :
                     ((r_signA ^ r_signB) ? (~r_acc[31:0] + 32'd1) : r_acc[31:0]);
   assign w_remFix = r_signA ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

   // State register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; a flush always wins and returns to IDLE.
   always_comb begin
      w_next = r_state;
      if (cancel) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (start) w_next = op[1] ? S_DIV : S_MUL;
            S_MUL:   if (r_cnt == 5'd1) w_next = S_DONE;
            S_DIV:   if (r_cnt == 5'd31) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   // Outputs; the stall drops in DONE so the instruction leaves EX then.
   always_comb begin
      md_stall = 1'b0;
      done     = 1'b0;
      busy     = resetn && (r_state != S_IDLE);
      if (resetn && !cancel) begin
         case (r_state)
            S_IDLE:                md_stall = start;
            S_MUL, S_DIV, S_FIX:   md_stall = 1'b1;
            S_DONE:                done     = 1'b1;
            default:               md_stall = 1'b0;
         endcase
      end
   end

   // Operand latch, iteration counter and the shared product/remainder register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_cnt     <= 5'd0;
         r_op      <= 2'b00;
         r_signA   <= 1'b0;
         r_signB   <= 1'b0;
         r_divZero <= 1'b0;
         r_a       <= 32'd0;
         r_b       <= 32'd0;
         r_acc     <= 64'd0;
      end else if (!cancel) begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_op      <= op;
                  r_signA   <= w_signedDiv & src_a[31];
                  r_signB   <= w_signedDiv & src_b[31];
                  r_divZero <= (src_b == 32'd0);
                  r_a       <= w_opA;
                  r_b       <= w_opB;
                  r_acc     <= {32'd0, w_opA};
                  r_cnt     <= 5'd0;
               end
            end
            S_MUL: begin
               if (r_cnt == 5'd0) begin
                  r_acc <= r_op[0] ? w_prodU : w_prodS;
               end
               r_cnt <= r_cnt + 5'd1;
            end
            S_DIV: begin
               if (w_trial[32]) begin
                  r_acc <= w_shift[63:0];
               end else begin
                  r_acc <= {w_trial[31:0], w_shift[31:1], 1'b1};
               end
               r_cnt <= r_cnt + 5'd1;
            end
            S_FIX: begin
               if (!r_op[0]) begin
                  r_acc <= {w_remFix, w_quoFix};
               end
            end
            default: begin
            end
         endcase
      end
   end

   // HI/LO: a committing mul/div is younger than MTHI/MTLO, so it wins.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_hi <= 32'd0;
         r_lo <= 32'd0;
      end else if ((r_state == S_DONE) && !cancel) begin
         r_hi <= r_acc[63:32];
         r_lo <= r_acc[31:0];
      end else begin
         if (hilo_we[1]) r_hi <= hilo_wdata;
         if (hilo_we[0]) r_lo <= hilo_wdata;
      end
   end

   assign hi = r_hi;
   assign lo = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: self-checking bench for muldiv_ctrl with a behavioural
// arithmetic reference model and randomized operations.
module tb_muldiv_ctrl;

   logic        clk;
   logic        resetn;
   logic        start;
   logic [1:0]  op;
   logic [31:0] srcA;
   logic [31:0] srcB;
   logic        cancel;
   logic [1:0]  hiloWe;
   logic [31:0] hiloWdata;
   logic        mdStall;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks;
   int failures;

   muldiv_ctrl dut (
      .clk        (clk),
      .resetn     (resetn),
      .start      (start),
      .op         (op),
      .src_a      (srcA),
      .src_b      (srcB),
      .cancel     (cancel),
      .hilo_we    (hiloWe),
      .hilo_wdata (hiloWdata),
      .md_stall   (mdStall),
      .busy       (busy),
      .done       (done),
      .hi         (hi),
      .lo         (lo)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: {hi, lo} from plain arithmetic on the operation's definition.
   function automatic logic [63:0] refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa;
      longint sb;
      longint q;
      longint r;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         2'b00: begin
            q = sa * sb;
            res = q;
         end
         2'b01: res = {32'd0, a} * {32'd0, b};
         2'b10: begin
            if (b == 32'd0) begin
               res = {a, 32'hFFFF_FFFF};
            end else begin
               q = sa / sb;
               r = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else res = {a % b, a / b};
         end
      endcase
      return res;
   endfunction

   // Issues one op starting now (just after a rising edge); returns stall count,
   // the cycle index of done (-1 on timeout) and hi/lo just after the commit edge.
   task automatic runOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int stalls, output int doneCyc,
                        output logic [31:0] hiOut, output logic [31:0] loOut);
      stalls  = 0;
      doneCyc = -1;
      start = 1'b1;
      op    = o;
      srcA  = a;
      srcB  = b;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (mdStall) stalls++;
         if (done) begin
            doneCyc = c;
            break;
         end
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      hiOut = hi;
      loOut = lo;
   endtask

   // Reset holds everything quiet even with start asserted.
   task automatic test_reset();
      resetn = 1'b0;
      start  = 1'b1;
      op     = 2'b10;
      srcA   = 32'd9;
      srcB   = 32'd3;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (hi !== 32'd0) begin failures++; $display("[TB] FAIL reset_hi got=%h exp=%h", hi, 32'd0); end
      checks++; if (lo !== 32'd0) begin failures++; $display("[TB] FAIL reset_lo got=%h exp=%h", lo, 32'd0); end
      checks++; if (mdStall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall got=%b exp=0", mdStall); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
      start = 1'b0;
      resetn = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_done got=%b exp=0", done); end
      @(posedge clk);
      #1;
   endtask

   // Directed multiply and divide cases with known results.
   task automatic test_directed();
      int st;
      int dc;
      logic [31:0] h;
      logic [31:0] l;
      runOp(2'b00, 32'hFFFF_FFFF, 32'd2, st, dc, h, l);
      checks++; if (st !== 3) begin failures++; $display("[TB] FAIL mult_stalls got=%0d exp=3", st); end
      checks++; if (dc !== 3) begin failures++; $display("[TB] FAIL mult_done_cycle got=%0d exp=3", dc); end
      checks++; if ({h, l} !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("[TB] FAIL mult_result got=%h_%h exp=ffffffff_fffffffe", h, l); end
      runOp(2'b01, 32'hFFFF_FFFF, 32'd2, st, dc, h, l);
      checks++; if ({h, l} !== 64'h0000_0001_FFFF_FFFE) begin failures++; $display("[TB] FAIL multu_result got=%h_%h exp=00000001_fffffffe", h, l); end
      runOp(2'b10, 32'hFFFF_FFF9, 32'd2, st, dc, h, l);
      checks++; if (st !== 34) begin failures++; $display("[TB] FAIL div_stalls got=%0d exp=34", st); end
      checks++; if (dc !== 34) begin failures++; $display("[TB] FAIL div_done_cycle got=%0d exp=34", dc); end
      checks++; if ({h, l} !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("[TB] FAIL div_neg_result got=%h_%h exp=ffffffff_fffffffd", h, l); end
      runOp(2'b11, 32'd100, 32'd7, st, dc, h, l);
      checks++; if ({h, l} !== 64'h0000_0002_0000_000E) begin failures++; $display("[TB] FAIL divu_result got=%h_%h exp=00000002_0000000e", h, l); end
      runOp(2'b11, 32'd5, 32'd0, st, dc, h, l);
      checks++; if ({h, l} !== 64'h0000_0005_FFFF_FFFF) begin failures++; $display("[TB] FAIL divu_zero got=%h_%h exp=00000005_ffffffff", h, l); end
      checks++; if (dc !== 34) begin failures++; $display("[TB] FAIL divzero_latency got=%0d exp=34", dc); end
      runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, st, dc, h, l);
      checks++; if ({h, l} !== 64'h0000_0000_8000_0000) begin failures++; $display("[TB] FAIL div_overflow got=%h_%h exp=00000000_80000000", h, l); end
      runOp(2'b10, 32'hFFFF_FFF9, 32'd0, st, dc, h, l);
      checks++; if ({h, l} !== 64'hFFFF_FFF9_FFFF_FFFF) begin failures++; $display("[TB] FAIL div_neg_zero got=%h_%h exp=fffffff9_ffffffff", h, l); end
   endtask

   // A flush in the middle of a divide must leave HI/LO untouched.
   task automatic test_cancel();
      int doneSeen;
      hiloWe    = 2'b11;
      hiloWdata = 32'h1234_5678;
      @(posedge clk);
      #1;
      hiloWe = 2'b00;
      start = 1'b1;
      op    = 2'b10;
      srcA  = 32'd100;
      srcB  = 32'd7;
      repeat (10) @(posedge clk);
      #1;
      cancel = 1'b1;
      @(negedge clk);
      checks++; if (mdStall !== 1'b0) begin failures++; $display("[TB] FAIL cancel_stall got=%b exp=0", mdStall); end
      checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL cancel_done got=%b exp=0", done); end
      @(posedge clk);
      #1;
      cancel = 1'b0;
      start  = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL cancel_idle_busy got=%b exp=0", busy); end
      doneSeen = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done || mdStall) doneSeen++;
      end
      checks++; if (doneSeen !== 0) begin failures++; $display("[TB] FAIL cancel_no_done got=%0d exp=0", doneSeen); end
      checks++; if ({hi, lo} !== 64'h1234_5678_1234_5678) begin failures++; $display("[TB] FAIL cancel_hilo got=%h_%h exp=12345678_12345678", hi, lo); end
      @(posedge clk);
      #1;
   endtask

   // MTHI/MTLO colliding with a DONE commit, then a plain MTHI in IDLE.
   task automatic test_hilo_write();
      start = 1'b1;
      op    = 2'b01;
      srcA  = 32'd3;
      srcB  = 32'd4;
      repeat (3) @(posedge clk);
      #1;
      hiloWe    = 2'b11;
      hiloWdata = 32'hAAAA_5555;
      @(negedge clk);
      checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL collide_done got=%b exp=1", done); end
      @(posedge clk);
      #1;
      hiloWe = 2'b00;
      start  = 1'b0;
      checks++; if ({hi, lo} !== 64'h0000_0000_0000_000C) begin failures++; $display("[TB] FAIL collide_hilo got=%h_%h exp=00000000_0000000c", hi, lo); end
      hiloWe    = 2'b10;
      hiloWdata = 32'hDEAD_BEEF;
      @(negedge clk);
      checks++; if (hi !== 32'd0) begin failures++; $display("[TB] FAIL mthi_before_edge got=%h exp=00000000", hi); end
      @(posedge clk);
      #1;
      hiloWe = 2'b00;
      checks++; if ({hi, lo} !== 64'hDEAD_BEEF_0000_000C) begin failures++; $display("[TB] FAIL mthi_after_edge got=%h_%h exp=deadbeef_0000000c", hi, lo); end
   endtask

   // Next op issued in the cycle after DONE must be accepted immediately.
   task automatic test_back_to_back();
      int st;
      int dc;
      logic [31:0] h;
      logic [31:0] l;
      runOp(2'b11, 32'd1000, 32'd33, st, dc, h, l);
      checks++; if ({h, l} !== refModel(2'b11, 32'd1000, 32'd33)) begin failures++; $display("[TB] FAIL b2b_first got=%h_%h", h, l); end
      runOp(2'b00, 32'hFFFF_FFFD, 32'd7, st, dc, h, l);
      checks++; if (dc !== 3 || st !== 3) begin failures++; $display("[TB] FAIL b2b_second_timing done=%0d stalls=%0d exp=3/3", dc, st); end
      checks++; if ({h, l} !== refModel(2'b00, 32'hFFFF_FFFD, 32'd7)) begin failures++; $display("[TB] FAIL b2b_second got=%h_%h", h, l); end
   endtask

   // Random operations against the arithmetic model.
   task automatic test_random();
      int st;
      int dc;
      int expCyc;
      logic [31:0] h;
      logic [31:0] l;
      logic [1:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
      for (int i = 0; i < 24; i++) begin
         o = 2'($urandom_range(0, 3));
         a = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: b = 32'($urandom_range(1, 15));
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 1000));
         exp = refModel(o, a, b);
         expCyc = o[1] ? 34 : 3;
         runOp(o, a, b, st, dc, h, l);
         checks++; if ({h, l} !== exp) begin failures++; $display("[TB] FAIL rand_result op=%b a=%h b=%h got=%h_%h exp=%h", o, a, b, h, l, exp); end
         checks++; if (dc !== expCyc || st !== expCyc) begin failures++; $display("[TB] FAIL rand_timing op=%b done=%0d stalls=%0d exp=%0d", o, dc, st, expCyc); end
      end
   endtask

   // Reset in the middle of a divide discards it.
   task automatic test_reset_mid();
      start = 1'b1;
      op    = 2'b11;
      srcA  = 32'd77;
      srcB  = 32'd5;
      repeat (5) @(posedge clk);
      #1;
      resetn = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      start  = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || mdStall !== 1'b0) begin failures++; $display("[TB] FAIL reset_mid busy=%b stall=%b exp=0/0", busy, mdStall); end
      checks++; if ({hi, lo} !== 64'd0) begin failures++; $display("[TB] FAIL reset_mid_hilo got=%h_%h exp=0_0", hi, lo); end
   endtask

   // Test sequence.
   initial begin
      checks    = 0;
      failures  = 0;
      resetn    = 1'b0;
      start     = 1'b0;
      op        = 2'b00;
      srcA      = 32'd0;
      srcB      = 32'd0;
      cancel    = 1'b0;
      hiloWe    = 2'b00;
      hiloWdata = 32'd0;
      test_reset();
      test_directed();
      test_cancel();
      test_hilo_write();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide sequencer and HI/LO register owner for the EX stage of the 5-stage MIPS pipeline. Accepts MULT/MULTU/DIV/DIVU from ID_EX, runs them over a fixed number of cycles, and holds the pipeline through a stall request. Commits the result to HI/LO unless the instruction is flushed by an exception. Also services MTHI/MTLO writes from WB.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  in  1  pipeline clock
- resetn  in  1  one clock; reset is synchronous and active-low
- start  in  1  ID_EX holds a mul/div instruction; held high while stalled
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  in  32  rs operand (dividend / multiplicand), already bypassed
- src_b  in  32  rt operand (divisor / multiplier), already bypassed
- cancel  in  1  EX_MEM_ex flush; aborts operation in flight
- hilo_we  in  2  [1]=MTHI, [0]=MTLO write from MEM_WB
- hilo_wdata  in  32  MTHI/MTLO data
- md_stall  out  1  freeze PC, IF_ID, ID_EX; bubble into EX_MEM
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when HI/LO committed
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, MUL, DIV, FIX, DONE. 5-bit iteration counter cnt.
- IDLE: if start && !cancel, latch op, signs and operands (absolute values for signed DIV), cnt=0; go MUL (op[1]=0) or DIV (op[1]=1). Otherwise stay.
- MUL: cycle 1 registers 64-bit product (signed for MULT, unsigned for MULTU); cycle 2 holds it. Go DONE when cnt==1.
- DIV: restoring radix-2, one quotient bit per cycle, 64-bit partial remainder. Go FIX when cnt==31.
- FIX: signed DIV only negates the quotient if the operand signs differ; the remainder takes the dividend's sign. DIVU passes through. Go DONE.
- DONE: hi<=high product/remainder, lo<=low product/quotient; done=1; go IDLE.
- md_stall = (state==IDLE && start && !cancel) || state in {MUL, DIV, FIX}. Low in DONE, so the instruction leaves EX at the end of the DONE cycle. No restart off a stale start.
- cancel: highest priority in every state. Go IDLE next cycle; no HI/LO write; no done; md_stall low in the cancel cycle.
- hilo_we: written in any state. If it coincides with DONE, the DONE write wins for that register, because the mul/div is younger.
- Divide by zero, any sign: lo=0xFFFFFFFF, hi=src_a; no exception; same latency.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Reset (resetn=0 at a clk edge): state=IDLE, cnt=0, hi=0, lo=0, done=0, busy=0. md_stall=0, overriding start. Reset mid-operation discards the operation.

## Timing
- Cycle 0 = first cycle start is seen in IDLE.
- MULT/MULTU: md_stall high cycles 0–2, DONE in cycle 3, hi/lo valid from cycle 4. 3 stall cycles.
- DIV/DIVU: md_stall high cycles 0–33 (DIV cycles 1–32, FIX 33), DONE in cycle 34, hi/lo valid from cycle 35. 34 stall cycles.
- done and the hi/lo update share one rising edge, at the end of DONE.
- hi/lo are registered, with no internal bypass; MFHI/MFLO forwarding stays in the bypass unit.
- Back-to-back mul/div: the next start is accepted in the cycle after DONE.

## Test plan
- Reset: hold resetn=0 with start=1 -> hi=lo=0, md_stall=0, busy=0; after release, IDLE.
- MULT 0xFFFFFFFF × 2 -> md_stall exactly 3 cycles, hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulse in cycle 3. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV -7 (0xFFFFFFF9) / 2 -> 34 stall cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=0x0000000E, hi=0x00000002.
- DIVU 5/0 -> lo=0xFFFFFFFF, hi=0x00000005. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- cancel at DIV cycle 10 with hi=lo=0x12345678 beforehand -> IDLE next cycle, hi/lo unchanged, no done, md_stall low from the cancel cycle on.
- hilo_we=2'b11, wdata=0xAAAA5555 in the DONE cycle of MULTU 3×4 -> hi=0, lo=0x0000000C. MTHI in IDLE -> hi updated next edge.
